// File: rtl/alu_pkg.sv
// Shared ALUop encoding, widths and execution-unit state encoding.
// The ALUop constants are the same ones the instruction decoder emits.
package alu_pkg;

  localparam int WIDTH        = 32;
  localparam int SHAMT_W      = 5;
  localparam int MULDIV_STEPS = 32;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIVU = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    MULDIV = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Shifts occupy the lowest three codes.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
  endfunction

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the issuing stage and the
// execution unit. master = issuer/consumer, slave = execution unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic             InValid;
  logic             InReady;
  logic [3:0]       ALUop;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result2;
  logic             Equal;
  logic             OutValid;
  logic             OutReady;

  modport master (
    output InValid, ALUop, X, Y, OutReady,
    input  InReady, Result, Result2, Equal, OutValid
  );

  modport slave (
    input  InValid, ALUop, X, Y, OutReady,
    output InReady, Result, Result2, Equal, OutValid
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider.
// One step per clock; STEPS steps after start the hi/lo pair holds
// product {hi,lo} or remainder (hi) / quotient (lo).
// done is high in the cycle whose closing edge performs the final step,
// so the controlling FSM can leave its wait state on that same edge.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(STEPS + 1);

  logic             busy_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // Step arithmetic: add multiplicand on lo[0]; trial-subtract divisor.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  // Control and the visible hi/lo pair; cleared by reset to abort work.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      cnt_q  <= CNT_W'(STEPS);
      hi_q   <= '0;
      lo_q   <= a;
    end else if (busy_q) begin
      if (div_q) begin
        if (!div_diff[WIDTH]) begin
          hi_q <= div_diff[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= div_shift[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  // Multiplicand / divisor operand, loaded at start only.
  always_ff @(posedge clk) begin
    if (start) opnd_q <= b;
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(1));
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit. Single-cycle logic/arithmetic ops,
// iterative 1-bit/cycle shifts, and 32-step mul/divu in a sub-module.
// One bundle in flight; results are held in DONE until taken.
module alu_exec_unit #(
  parameter int WIDTH        = 32,
  parameter int MULDIV_STEPS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_exec_unit_if.slave       bus
);
  import alu_pkg::*;

  state_t             state;
  state_t             state_next;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   result_q;
  logic               equal_q;
  logic [SHAMT_W-1:0] shcnt_q;

  logic               accept;
  logic               md_start;
  logic               md_busy;
  logic               md_done;
  logic [WIDTH-1:0]   md_hi;
  logic [WIDTH-1:0]   md_lo;
  logic               md_sel;

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = (sa < sb) ? WIDTH'(1) : '0;
      ALU_SLTU: r = (a < b) ? WIDTH'(1) : '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0]        r;
    sv = v;
    case (op)
      ALU_SLL: r = {v[WIDTH-2:0], 1'b0};
      ALU_SRA: r = sv >>> 1;
      ALU_SRL: r = {1'b0, v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign accept = bus.InValid && (state == IDLE);
  assign md_sel = is_muldiv_op(op_q);

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .STEPS (MULDIV_STEPS)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (bus.ALUop == ALU_DIVU),
    .a      (bus.X),
    .b      (bus.Y),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and mul/div launch.
  always_comb begin
    state_next = state;
    md_start   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift_op(bus.ALUop)) begin
            state_next = (bus.Y[SHAMT_W-1:0] == '0) ? DONE : SHIFT;
          end else if (is_muldiv_op(bus.ALUop)) begin
            state_next = MULDIV;
            md_start   = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      SHIFT:   if (shcnt_q == SHAMT_W'(1)) state_next = DONE;
      MULDIV:  if (md_busy && md_done) state_next = DONE;
      DONE:    if (bus.OutReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, single-cycle result and the iterative shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= ALU_SLL;
      result_q <= '0;
      equal_q  <= 1'b0;
      shcnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= bus.ALUop;
            equal_q  <= (bus.X == bus.Y);
            shcnt_q  <= bus.Y[SHAMT_W-1:0];
            result_q <= is_shift_op(bus.ALUop) ? bus.X
                                               : alu_single(bus.ALUop, bus.X, bus.Y);
          end
        end
        SHIFT: begin
          result_q <= shift_step(op_q, result_q);
          shcnt_q  <= shcnt_q - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.InReady  = (state == IDLE);
  assign bus.OutValid = (state == DONE);
  assign bus.Result   = md_sel ? md_lo : result_q;
  assign bus.Result2  = md_sel ? md_hi : '0;
  assign bus.Equal    = equal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are pushed when a
// bundle is issued and popped when OutValid is seen.
module tb_alu_exec_unit;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] r;
    logic [31:0] r2;
    logic        eq;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  alu_exec_unit_if #(.WIDTH(32)) bus();

  alu_exec_unit #(.WIDTH(32), .MULDIV_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    e.r2  = 32'd0;
    e.eq  = (x == y);
    e.lat = 1;
    case (op)
      4'd0: begin e.r = x << y[4:0]; e.lat = int'(y[4:0]) + 1; end
      4'd1: begin e.r = $signed(x) >>> y[4:0]; e.lat = int'(y[4:0]) + 1; end
      4'd2: begin e.r = x >> y[4:0]; e.lat = int'(y[4:0]) + 1; end
      4'd3: begin p = {32'd0, x} * {32'd0, y}; e.r = p[31:0]; e.r2 = p[63:32]; e.lat = 33; end
      4'd4: begin
        e.lat = 33;
        if (y == 0) begin e.r = 32'hFFFFFFFF; e.r2 = x; end
        else begin e.r = x / y; e.r2 = x % y; end
      end
      4'd5:  e.r = x + y;
      4'd6:  e.r = x - y;
      4'd7:  e.r = x & y;
      4'd8:  e.r = x | y;
      4'd9:  e.r = x ^ y;
      4'd10: e.r = ~(x | y);
      4'd11: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd12: e.r = (x < y) ? 32'd1 : 32'd0;
      default: e.r = 32'd0;
    endcase
    return e;
  endfunction

  // Issue one bundle, push its expectation, wait for OutValid, then take it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [31:0] r2, output logic eq,
                        output int lat, output int acc_cyc);
    int guard;
    guard = 0;
    while (!bus.InReady && guard < 200) begin tick(); guard++; end
    sb.push_back(model(op, x, y));
    bus.InValid = 1'b1; bus.ALUop = op; bus.X = x; bus.Y = y;
    tick();
    acc_cyc = cyc;
    bus.InValid = 1'b0;
    lat = 1;
    while (!bus.OutValid && lat < 200) begin tick(); lat++; end
    r = bus.Result; r2 = bus.Result2; eq = bus.Equal;
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    compared += 4;
    if (bus.Result !== 32'd0) begin mismatched++; $display("FAIL reset_result got %h want 0", bus.Result); end
    if (bus.Result2 !== 32'd0) begin mismatched++; $display("FAIL reset_result2 got %h want 0", bus.Result2); end
    if (bus.OutValid !== 1'b0) begin mismatched++; $display("FAIL reset_outvalid got %b want 0", bus.OutValid); end
    if (bus.InReady !== 1'b1) begin mismatched++; $display("FAIL reset_inready got %b want 1", bus.InReady); end
    // abort a multiply part-way through
    bus.InValid = 1'b1; bus.ALUop = ALU_MUL; bus.X = 32'd7; bus.Y = 32'd9;
    tick();
    bus.InValid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared += 3;
    if (bus.OutValid !== 1'b0) begin mismatched++; $display("FAIL abort_outvalid got %b want 0", bus.OutValid); end
    if (bus.InReady !== 1'b1) begin mismatched++; $display("FAIL abort_inready got %b want 1", bus.InReady); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.OutValid) seen++; end
    if (seen != 0) begin mismatched++; $display("FAIL abort_no_output got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_ops(input string nm, input logic [3:0] ops[], input logic [31:0] xs[],
                          input logic [31:0] ys[]);
    logic [31:0] r, r2;
    logic        eq;
    int          lat, ac;
    exp_t        e;
    for (int i = 0; i < ops.size(); i++) begin
      run_op(ops[i], xs[i], ys[i], r, r2, eq, lat, ac);
      e = sb.pop_front();
      compared += 4;
      if (r !== e.r) begin mismatched++; $display("FAIL %s[%0d] op%0d result got %h want %h", nm, i, ops[i], r, e.r); end
      if (r2 !== e.r2) begin mismatched++; $display("FAIL %s[%0d] op%0d result2 got %h want %h", nm, i, ops[i], r2, e.r2); end
      if (eq !== e.eq) begin mismatched++; $display("FAIL %s[%0d] op%0d equal got %b want %b", nm, i, ops[i], eq, e.eq); end
      if (lat != e.lat) begin mismatched++; $display("FAIL %s[%0d] op%0d latency got %0d want %0d", nm, i, ops[i], lat, e.lat); end
    end
  endtask

  task automatic test_single();
    logic [3:0]  ops[] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, 4'd14, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR};
    logic [31:0] xs[]  = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555, 32'h1200_0000};
    logic [31:0] ys[]  = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h99, 32'h0FF0_FF00, 32'h00F0_0010, 32'hFFFF_0000, 32'h0000_0034};
    test_ops("single", ops, xs, ys);
  endtask

  task automatic test_shift();
    logic [3:0]  ops[] = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_SLL, ALU_SRA};
    logic [31:0] xs[]  = '{32'h80000000, 32'h80000000, 32'd1, 32'd1, 32'h4000_0001};
    logic [31:0] ys[]  = '{32'd4, 32'd4, 32'd0, 32'd31, 32'hFFFF_FFE3};
    test_ops("shift", ops, xs, ys);
  endtask

  task automatic test_muldiv();
    logic [3:0]  ops[] = '{ALU_MUL, ALU_DIVU, ALU_DIVU, ALU_MUL, ALU_DIVU};
    logic [31:0] xs[]  = '{32'hFFFFFFFF, 32'd100, 32'h1234, 32'h0001_0003, 32'hFFFF_FFFF};
    logic [31:0] ys[]  = '{32'hFFFFFFFF, 32'd7, 32'd0, 32'h8000_0005, 32'h8000_0001};
    test_ops("muldiv", ops, xs, ys);
  endtask

  task automatic test_random();
    logic [3:0]  ops[];
    logic [31:0] xs[];
    logic [31:0] ys[];
    ops = new[24]; xs = new[24]; ys = new[24];
    for (int i = 0; i < 24; i++) begin
      ops[i] = 4'($urandom_range(0, 15));
      xs[i]  = $urandom();
      ys[i]  = (i % 6 == 5) ? xs[i] : $urandom();
    end
    test_ops("random", ops, xs, ys);
  endtask

  task automatic test_backpressure();
    exp_t        e;
    logic [31:0] r0, r20;
    int          seen;
    while (!bus.InReady) tick();
    sb.push_back(model(ALU_XOR, 32'h1357_9BDF, 32'h0F0F_0F0F));
    bus.InValid = 1'b1; bus.ALUop = ALU_XOR; bus.X = 32'h1357_9BDF; bus.Y = 32'h0F0F_0F0F;
    tick();
    bus.InValid = 1'b0;
    e = sb.pop_front();
    r0 = bus.Result; r20 = bus.Result2;
    compared += 2;
    if (bus.OutValid !== 1'b1) begin mismatched++; $display("FAIL bp_first_valid got %b want 1", bus.OutValid); end
    if (r0 !== e.r) begin mismatched++; $display("FAIL bp_result got %h want %h", r0, e.r); end
    for (int i = 0; i < 5; i++) begin
      bus.InValid = 1'b1; bus.ALUop = ALU_ADD; bus.X = 32'd9 + i; bus.Y = 32'd3;
      tick();
      compared += 4;
      if (bus.OutValid !== 1'b1) begin mismatched++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, bus.OutValid); end
      if (bus.InReady !== 1'b0) begin mismatched++; $display("FAIL bp_hold_inready[%0d] got %b want 0", i, bus.InReady); end
      if (bus.Result !== e.r) begin mismatched++; $display("FAIL bp_hold_result[%0d] got %h want %h", i, bus.Result, e.r); end
      if (bus.Result2 !== r20) begin mismatched++; $display("FAIL bp_hold_result2[%0d] got %h want %h", i, bus.Result2, r20); end
    end
    bus.InValid = 1'b0;
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
    compared += 2;
    if (bus.InReady !== 1'b1) begin mismatched++; $display("FAIL bp_release_inready got %b want 1", bus.InReady); end
    if (bus.OutValid !== 1'b0) begin mismatched++; $display("FAIL bp_release_outvalid got %b want 0", bus.OutValid); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (bus.OutValid) seen++; end
    compared++;
    if (seen != 0) begin mismatched++; $display("FAIL bp_ignored_input got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, r2;
    logic        eq;
    int          lat, ac, prev;
    exp_t        e;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      run_op(ALU_ADD, 32'd100 * i, 32'd3, r, r2, eq, lat, ac);
      e = sb.pop_front();
      compared += 2;
      if (r !== e.r) begin mismatched++; $display("FAIL b2b[%0d] result got %h want %h", i, r, e.r); end
      if (lat != e.lat) begin mismatched++; $display("FAIL b2b[%0d] latency got %0d want %0d", i, lat, e.lat); end
      if (prev >= 0) begin
        compared++;
        if (ac - prev != 2) begin mismatched++; $display("FAIL b2b[%0d] issue spacing got %0d want 2", i, ac - prev); end
      end
      prev = ac;
    end
  endtask

  initial begin
    bus.InValid = 1'b0; bus.ALUop = 4'd0; bus.X = 32'd0; bus.Y = 32'd0; bus.OutReady = 1'b0;
    test_reset();
    test_single();
    test_shift();
    test_muldiv();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
